fht_input_loader: RTL

FHT_INPUT_LOADER -- requirements
Module: fht_input_loader

---
 rtl/fht_pkg.sv | 25 ++
 rtl/fht_input_loader_if.sv | 34 +++
 rtl/fht_bitrev.sv | 14 +
 rtl/fht_input_loader.sv | 93 +++++++++
 4 files changed

// File: rtl/fht_pkg.sv
// Shared FHT definitions: frame size, bank count, loader state encoding
// and a bit-reverse helper for code that wants the reversal as a function.
package fht_pkg;

    localparam int N_POINTS = 1024;
    localparam int N_BANK   = 4;
    localparam int CNT_BIT  = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } loader_state_t;

    function automatic logic [CNT_BIT-1:0] bit_reverse(input logic [CNT_BIT-1:0] v);
        logic [CNT_BIT-1:0] r;
        for (int i = 0; i < CNT_BIT; i++) begin
            r[i] = v[CNT_BIT-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_input_loader_if.sv
// Sample stream in, bank write port out, plus the FHT controller hand-off.
//
// Sample handshake: a sample on iDATA is transferred on a rising edge where
// iVALID and oREADY are both high and iABORT is low. oREADY does not depend
// on iVALID. iVALID with oREADY low is simply ignored; the source keeps or
// drops the sample as it likes, the loader stores nothing.
interface fht_input_loader_if #(
    parameter int D_BIT = 16,
    parameter int A_BIT = 8
);
    import fht_pkg::*;

    logic [D_BIT-1:0]  iDATA;
    logic              iVALID;
    logic              oREADY;
    logic              iABORT;
    logic              iFHT_RDY;
    logic              oSTART;
    logic [A_BIT-1:0]  oADDR_WR;
    logic [D_BIT-1:0]  oDATA_WR;
    logic [N_BANK-1:0] oWE;
    logic              oBUSY;

    modport master (
        output iDATA, iVALID, iABORT, iFHT_RDY,
        input  oREADY, oSTART, oADDR_WR, oDATA_WR, oWE, oBUSY
    );

    modport slave (
        input  iDATA, iVALID, iABORT, iFHT_RDY,
        output oREADY, oSTART, oADDR_WR, oDATA_WR, oWE, oBUSY
    );

endinterface

// File: rtl/fht_bitrev.sv
// Purely combinational bit reversal of a W-bit word.
module fht_bitrev #(
    parameter int W = 10
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    // Mirror the bit order: dout[i] = din[W-1-i].
    for (genvar i = 0; i < W; i++) begin : g_rev
        assign dout[i] = din[W-1-i];
    end

endmodule

// File: rtl/fht_input_loader.sv
// FHT input loader: accepts a 1024-sample frame, scatters it over four
// memory banks, then starts the FHT controller and waits for it to finish.
// Define FHT_LOADER_BITREV_EN to store samples in bit-reversed order;
// without it samples are stored in natural order.
module fht_input_loader
    import fht_pkg::*;
#(
    parameter int D_BIT = 16,
    parameter int A_BIT = 8
) (
    input  logic                iCLK_2,
    input  logic                iRESET,
    fht_input_loader_if.slave   bus,
    output loader_state_t       state_dbg
);

    localparam int CNT_W = A_BIT + 2;   // two extra bits select the bank

    loader_state_t     state, state_nxt;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  r;
    logic              accept;
    logic [N_BANK-1:0] we_q;
    logic [A_BIT-1:0]  addr_q;
    logic [D_BIT-1:0]  data_q;

    // An abort cycle never writes, even if a sample is offered.
    assign accept = bus.iVALID && (state == LOAD) && !bus.iABORT;

`ifdef FHT_LOADER_BITREV_EN
    fht_bitrev #(.W(CNT_W)) u_bitrev (
        .din  (n_q),
        .dout (r)
    );
`else
    assign r = n_q;
`endif

    // State register.
    always_ff @(posedge iCLK_2 or negedge iRESET) begin
        if (!iRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (bus.iABORT) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (bus.iFHT_RDY)  state_nxt = LOAD;
                LOAD:      if (accept && (&n_q)) state_nxt = START;
                START:     state_nxt = WAIT_BUSY;
                WAIT_BUSY: if (!bus.iFHT_RDY) state_nxt = WAIT_DONE;
                WAIT_DONE: if (bus.iFHT_RDY)  state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Sample counter; wraps to 0 naturally after the last sample of a frame.
    always_ff @(posedge iCLK_2 or negedge iRESET) begin
        if (!iRESET)         n_q <= '0;
        else if (bus.iABORT) n_q <= '0;
        else if (accept)     n_q <= n_q + 1'b1;
    end

    // Bank write port, one cycle behind the accept; enable is a single pulse.
    always_ff @(posedge iCLK_2 or negedge iRESET) begin
        if (!iRESET) begin
            we_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= '0;
            if (accept) begin
                we_q   <= N_BANK'(1) << r[CNT_W-1 -: 2];
                addr_q <= r[A_BIT-1:0];
                data_q <= bus.iDATA;
            end
        end
    end

    assign bus.oREADY   = (state == LOAD);
    assign bus.oSTART   = (state == START);
    assign bus.oBUSY    = (state != IDLE);
    assign bus.oWE      = we_q;
    assign bus.oADDR_WR = addr_q;
    assign bus.oDATA_WR = data_q;
    assign state_dbg    = state;

endmodule
